// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the writeback path.
package rf_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // One-hot register mask for a destination address.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        reg_onehot    = '0;
        reg_onehot[a] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pure combinational round-robin search: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin share of the RF write port with a one-entry registered output stage.
// Optional read bypass of the in-flight write under RF_WB_BYPASS_EN.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hold,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NREQ*XLEN-1:0]       req_data,
    output logic                       WE3,
    output logic [REG_ADDR_W-1:0]      A3,
    output logic [XLEN-1:0]            WD3,
    output logic [NUM_REGS-1:0]        pending_mask
`ifdef RF_WB_BYPASS_EN
   ,input  logic [REG_ADDR_W-1:0]      rs1_addr,
    input  logic [REG_ADDR_W-1:0]      rs2_addr,
    input  logic [XLEN-1:0]            rs1_rf,
    input  logic [XLEN-1:0]            rs2_rf,
    output logic [XLEN-1:0]            rs1_data,
    output logic [XLEN-1:0]            rs2_data
`endif
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    wb_req_t          req [NREQ];
    logic [NREQ-1:0]  req_elig;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    wb_req_t          win;

    logic [IDX_W-1:0]      ptr_q,  ptr_d;
    logic                  we_q,   we_d;
    logic [REG_ADDR_W-1:0] a3_q,   a3_d;
    logic [XLEN-1:0]       wd3_q,  wd3_d;
    logic [NUM_REGS-1:0]   pend_q, pend_d;

    for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
        assign req[i].addr = req_addr[REG_ADDR_W*i +: REG_ADDR_W];
        assign req[i].data = req_data[XLEN*i +: XLEN];
    end

    // Reset and hold both suppress every grant; the pointer then stays put.
    assign req_elig = (rst || hold) ? '0 : req_valid;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i   (req_elig),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .valid_o (grant_any)
    );

    assign req_ready = grant;
    assign win       = req[grant_idx];

    always_comb begin
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        a3_d   = a3_q;
        wd3_d  = wd3_q;
        pend_d = '0;
        if (grant_any) begin
            ptr_d = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            // Writes to x0 are accepted but never reach the RF.
            we_d  = (win.addr != '0);
            a3_d  = win.addr;
            wd3_d = win.data;
            if (we_d) begin
                pend_d = reg_onehot(win.addr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            we_q   <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            pend_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            pend_q <= pend_d;
        end
    end

    assign WE3          = we_q;
    assign A3           = a3_q;
    assign WD3          = wd3_q;
    assign pending_mask = pend_q;

`ifdef RF_WB_BYPASS_EN
    assign rs1_data = (we_q && (a3_q == rs1_addr) && (rs1_addr != '0)) ? wd3_q : rs1_rf;
    assign rs2_data = (we_q && (a3_q == rs2_addr) && (rs2_addr != '0)) ? wd3_q : rs2_rf;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (NREQ=2); bypass checks only when RF_WB_BYPASS_EN is defined.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] pending_mask;
`ifdef RF_WB_BYPASS_EN
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_rf, rs2_rf, rs1_data, rs2_data;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    rf_wb_arbiter #(.NREQ(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .WE3          (WE3),
        .A3           (A3),
        .WD3          (WD3),
        .pending_mask (pending_mask)
`ifdef RF_WB_BYPASS_EN
       ,.rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_rf       (rs1_rf),
        .rs2_rf       (rs2_rf),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[5*i +: 5]   = a;
        req_data[32*i +: 32] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = 2'b11;
        req_addr  = '0;
        req_data  = '0;
`ifdef RF_WB_BYPASS_EN
        rs1_addr = '0; rs2_addr = '0; rs1_rf = '0; rs2_rf = '0;
`endif
        set_req(0, 5'd1, 32'h1111_0001);
        set_req(1, 5'd2, 32'h2222_0002);

        // Reset with both requesters valid: nothing granted, stage cleared.
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("rst_ready", 32'(req_ready), 32'h0);
            tick();
            chk("rst_we3", 32'(WE3), 32'h0);
            chk("rst_pend", pending_mask, 32'h0);
            chk("rst_a3", 32'(A3), 32'h0);
            chk("rst_wd3", WD3, 32'h0);
        end
        rst       = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("idle_ready", 32'(req_ready), 32'h0);
        tick();
        chk("idle_we3", 32'(WE3), 32'h0);

        // Single request from requester 0 (pointer 0 -> 1).
        req_valid = 2'b01;
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("single_we3", 32'(WE3), 32'h1);
        chk("single_a3", 32'(A3), 32'd5);
        chk("single_wd3", WD3, 32'hDEAD_BEEF);
        chk("single_pend", pending_mask, 32'h0000_0020);
        tick();
        chk("single_we3_off", 32'(WE3), 32'h0);
        chk("single_a3_held", 32'(A3), 32'd5);
        chk("single_wd3_held", WD3, 32'hDEAD_BEEF);
        chk("single_pend_off", pending_mask, 32'h0);

        // x0 write from requester 1 (pointer 1 -> 0): accepted, no RF write.
        req_valid = 2'b10;
        set_req(1, 5'd0, 32'd7);
        #1;
        chk("x0_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        chk("x0_we3", 32'(WE3), 32'h0);
        chk("x0_pend", pending_mask, 32'h0);

        // Contention: grants alternate 0,1,0,1 with A3 following 1,2,1,2.
        req_valid = 2'b11;
        set_req(0, 5'd1, 32'hA0A0_0001);
        set_req(1, 5'd2, 32'hB0B0_0002);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("cont_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk("cont_we3", 32'(WE3), 32'h1);
            chk("cont_a3", 32'(A3), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_wd3", WD3, (k % 2 == 0) ? 32'hA0A0_0001 : 32'hB0B0_0002);
            chk("cont_pend", pending_mask, (k % 2 == 0) ? 32'h2 : 32'h4);
        end
        req_valid = 2'b00;
        tick();

        // Hold after a grant: staged write still pulses, pointer frozen at 1.
        req_valid = 2'b01;
        set_req(0, 5'd9, 32'h0000_0099);
        set_req(1, 5'd3, 32'h0000_0033);
        #1;
        chk("hold_pre_ready", 32'(req_ready), 32'h1);
        tick();
        hold      = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("hold_we3", 32'(WE3), 32'h1);
        chk("hold_a3", 32'(A3), 32'd9);
        chk("hold_ready", 32'(req_ready), 32'h0);
        tick();
        chk("hold_we3_off", 32'(WE3), 32'h0);
        chk("hold_pend_off", pending_mask, 32'h0);
        chk("hold_ready2", 32'(req_ready), 32'h0);
        tick();
        chk("hold_ready3", 32'(req_ready), 32'h0);
        hold = 1'b0;
        #1;
        chk("release_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        chk("release_we3", 32'(WE3), 32'h1);
        chk("release_a3", 32'(A3), 32'd3);
        chk("release_wd3", WD3, 32'h0000_0033);
        chk("release_pend", pending_mask, 32'h0000_0008);

`ifdef RF_WB_BYPASS_EN
        // Bypass of staged x7 write.
        req_valid = 2'b01;
        set_req(0, 5'd7, 32'h55);
        tick();
        req_valid = 2'b00;
        rs1_addr  = 5'd7;
        rs1_rf    = 32'h11;
        rs2_addr  = 5'd8;
        rs2_rf    = 32'h22;
        #1;
        chk("byp_rs1_hit", rs1_data, 32'h55);
        chk("byp_rs2_miss", rs2_data, 32'h22);
        rs1_addr = 5'd0;
        #1;
        chk("byp_rs1_x0", rs1_data, 32'h11);
        tick();
        rs1_addr = 5'd7;
        #1;
        chk("byp_rs1_idle", rs1_data, 32'h11);
`endif

        tick();
        chk("final_we3", 32'(WE3), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
